nn_row_window: RTL and testbench

- Downstream consumer of the DMA read buffer.
- Takes 48-bit row beats (i_buf_data/i_buf_ready) and keeps the last K rows in a shift stack; K is set by mode.
- Emits a K-row vertical window with a configurable vertical stride, through a valid/ready register to the PE array.
- The buffer cannot be back-pressured, so window loss is flagged rather than stalled.

---
 rtl/nn_row_window_pkg.sv | 55 +++++
 rtl/nn_row_window_if.sv | 26 ++
 rtl/nn_row_stack.sv | 45 ++++
 rtl/nn_row_window.sv | 129 ++++++++++++
 tb/tb_nn_row_window.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/nn_row_window_pkg.sv
// Shared types, constants and mode lookups for the row-window block.
// Latency: none; constants and combinational helper functions only.
// Backpressure: not applicable.
package nn_pkg;

    localparam int ROW_WIDTH = 48;
    localparam int MAX_K     = 6;
    localparam int IDX_WIDTH = 16;

    localparam logic [1:0] NN_MODE_3X3 = 2'b00;
    localparam logic [1:0] NN_MODE_4X4 = 2'b01;
    localparam logic [1:0] NN_MODE_5X5 = 2'b10;
    localparam logic [1:0] NN_MODE_6X6 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SLIDE = 2'd2
    } state_t;

    // Window height for a mode.
    function automatic logic [2:0] mode_k(input logic [1:0] mode);
        logic [2:0] k;
        case (mode)
            NN_MODE_3X3: k = 3'd3;
            NN_MODE_4X4: k = 3'd4;
            NN_MODE_5X5: k = 3'd5;
            default:     k = 3'd6;
        endcase
        return k;
    endfunction

    // Valid bytes per row for a mode (3x3 rows still carry 6 bytes).
    function automatic logic [2:0] mode_bytes(input logic [1:0] mode);
        logic [2:0] b;
        case (mode)
            NN_MODE_3X3: b = 3'd6;
            NN_MODE_4X4: b = 3'd4;
            NN_MODE_5X5: b = 3'd5;
            default:     b = 3'd6;
        endcase
        return b;
    endfunction

    // Byte-granular mask keeping only the low mode_bytes bytes of a row.
    function automatic logic [ROW_WIDTH-1:0] row_mask(input logic [1:0] mode);
        logic [ROW_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < ROW_WIDTH / 8; b++) begin
            if (b < int'(mode_bytes(mode))) m[b*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/nn_row_window_if.sv
// Row-beat input and window output bundle of nn_row_window.
// Latency: wires only.
// Backpressure: beats have none; windows use o_win_valid / i_win_ready.
interface nn_row_window_if;
    import nn_pkg::*;

    logic [ROW_WIDTH-1:0]       i_buf_data;
    logic                       i_buf_ready;
    logic [MAX_K*ROW_WIDTH-1:0] o_win_data;
    logic                       o_win_valid;
    logic                       i_win_ready;
    logic [IDX_WIDTH-1:0]       o_win_idx;

    // master: the window block itself
    modport master (
        input  i_buf_data, i_buf_ready, i_win_ready,
        output o_win_data, o_win_valid, o_win_idx
    );

    // slave: read buffer + PE array side
    modport slave (
        output i_buf_data, i_buf_ready, i_win_ready,
        input  o_win_data, o_win_valid, o_win_idx
    );

endinterface

// File: rtl/nn_row_stack.sv
// Masked shift stack of the last K rows; new row enters slot K-1, slot 0 drops out.
// Latency: rows_nxt is the combinational next state (includes this cycle's beat).
// Backpressure: none; a shift happens on every asserted shift.
// Ports: i_clk/i_rst, clr (empty the stack), shift + din/mask/k (capture a row),
//        rows_nxt (stack contents after this cycle, slot 0 in the low bits).
module nn_row_stack
    import nn_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       clr,
    input  logic                       shift,
    input  logic [2:0]                 k,
    input  logic [ROW_WIDTH-1:0]       mask,
    input  logic [ROW_WIDTH-1:0]       din,
    output logic [MAX_K*ROW_WIDTH-1:0] rows_nxt
);

    logic [MAX_K*ROW_WIDTH-1:0] rows_q;
    logic [MAX_K*ROW_WIDTH-1:0] base;
    logic [MAX_K*ROW_WIDTH-1:0] shifted;

    // Clear is applied before the shift so a same-cycle beat becomes row 0.
    always_comb begin
        base     = clr ? '0 : rows_q;
        shifted  = base >> ROW_WIDTH;
        rows_nxt = base;
        if (shift) begin
            for (int i = 0; i < MAX_K; i++) begin
                if (i < int'(k) - 1)
                    rows_nxt[i*ROW_WIDTH +: ROW_WIDTH] = shifted[i*ROW_WIDTH +: ROW_WIDTH];
                else if (i == int'(k) - 1)
                    rows_nxt[i*ROW_WIDTH +: ROW_WIDTH] = din & mask;
                else
                    rows_nxt[i*ROW_WIDTH +: ROW_WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) rows_q <= '0;
        else        rows_q <= rows_nxt;
    end

endmodule

// File: rtl/nn_row_window.sv
// K-row vertical window generator with stride 1/2 feeding the PE array.
// Latency: window valid one cycle after the completing beat.
// Backpressure: beats cannot stall; an unaccepted window is overwritten and o_overflow sticks.
// Ports: i_clk/i_rst, i_frame_start/i_mode/i_stride (frame setup), bus (beats in,
//        windows out), o_overflow (sticky loss flag), o_busy (frame active).
// Build option NN_ROW_WINDOW_ZERO_PAD_EN: each frame starts with one zero row
// already in the stack, so the first window needs only K-1 beats.
module nn_row_window
    import nn_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic [1:0]        i_mode,
    input  logic              i_stride,
    nn_row_window_if.master   bus,
    output logic              o_overflow,
    output logic              o_busy
);

`ifdef NN_ROW_WINDOW_ZERO_PAD_EN
    localparam logic [2:0] ROW_CNT_START = 3'd1;
`else
    localparam logic [2:0] ROW_CNT_START = 3'd0;
`endif

    state_t               state_q, state_d, state_eff;
    logic [1:0]           mode_q, mode_eff;
    logic                 stride_q, stride_eff;
    logic [2:0]           row_cnt_q, row_cnt_d, row_cnt_eff;
    logic                 stride_cnt_q, stride_cnt_d, stride_cnt_eff;
    logic [IDX_WIDTH-1:0] win_cnt_q, win_cnt_eff;
    logic                 capture;
    logic                 emit;
    logic [MAX_K*ROW_WIDTH-1:0] rows_nxt;

    // A frame start resets the frame context first; the rest of the cycle
    // (including a coincident beat) then runs against that fresh context.
    always_comb begin
        mode_eff       = i_frame_start ? i_mode        : mode_q;
        stride_eff     = i_frame_start ? i_stride      : stride_q;
        state_eff      = i_frame_start ? ST_FILL       : state_q;
        row_cnt_eff    = i_frame_start ? ROW_CNT_START : row_cnt_q;
        stride_cnt_eff = i_frame_start ? 1'b0          : stride_cnt_q;
        win_cnt_eff    = i_frame_start ? '0            : win_cnt_q;

        capture      = (state_eff != ST_IDLE) && bus.i_buf_ready;
        state_d      = state_eff;
        row_cnt_d    = row_cnt_eff;
        stride_cnt_d = stride_cnt_eff;
        emit         = 1'b0;

        if (capture) begin
            case (state_eff)
                ST_FILL: begin
                    row_cnt_d = row_cnt_eff + 3'd1;
                    if (row_cnt_eff + 3'd1 == mode_k(mode_eff)) begin
                        emit    = 1'b1;
                        state_d = ST_SLIDE;
                    end
                end
                ST_SLIDE: begin
                    // stride 2: first further beat arms, second emits
                    if (!stride_eff || stride_cnt_eff) begin
                        emit         = 1'b1;
                        stride_cnt_d = 1'b0;
                    end else begin
                        stride_cnt_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    nn_row_stack u_stack (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .clr      (i_frame_start),
        .shift    (capture),
        .k        (mode_k(mode_eff)),
        .mask     (row_mask(mode_eff)),
        .din      (bus.i_buf_data),
        .rows_nxt (rows_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mode_q          <= '0;
            stride_q        <= 1'b0;
            row_cnt_q       <= '0;
            stride_cnt_q    <= 1'b0;
            win_cnt_q       <= '0;
            bus.o_win_data  <= '0;
            bus.o_win_valid <= 1'b0;
            bus.o_win_idx   <= '0;
            o_overflow      <= 1'b0;
        end else begin
            mode_q       <= mode_eff;
            stride_q     <= stride_eff;
            row_cnt_q    <= row_cnt_d;
            stride_cnt_q <= stride_cnt_d;
            win_cnt_q    <= win_cnt_eff;
            if (i_frame_start) begin
                bus.o_win_idx <= '0;
                o_overflow    <= 1'b0;
            end
            // A pending window survives a frame start; only i_win_ready or a
            // newer window retires it.
            if (emit) begin
                if (bus.o_win_valid && !bus.i_win_ready) o_overflow <= 1'b1;
                bus.o_win_data  <= rows_nxt;
                bus.o_win_valid <= 1'b1;
                bus.o_win_idx   <= win_cnt_eff;
                win_cnt_q       <= win_cnt_eff + 1'b1;
            end else if (bus.i_win_ready) begin
                bus.o_win_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nn_row_window.sv
// Randomized bench for nn_row_window against a queue-based reference model.
// Latency: checks each cycle on the falling edge after the model step.
// Backpressure: drives i_win_ready both held low and random.
module tb_nn_row_window;
    import nn_pkg::*;

    localparam int WW = MAX_K * ROW_WIDTH;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_frame_start = 1'b0;
    logic [1:0] i_mode = 2'b00;
    logic       i_stride = 1'b0;
    logic       o_overflow;
    logic       o_busy;

    nn_row_window_if bus ();

    nn_row_window dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_frame_start (i_frame_start),
        .i_mode        (i_mode),
        .i_stride      (i_stride),
        .bus           (bus),
        .o_overflow    (o_overflow),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame rows as a list, windows cut from its tail.
    logic [ROW_WIDTH-1:0] m_rows[$];
    int                   m_n;
    int                   m_cnt;
    bit                   m_active;
    logic [1:0]           m_mode;
    logic                 m_stride;
    logic                 m_valid;
    logic [WW-1:0]        m_data;
    logic [IDX_WIDTH-1:0] m_idx;
    logic                 m_over;

    task automatic model_reset();
        m_rows.delete();
        m_n = 0; m_cnt = 0; m_active = 0; m_mode = '0; m_stride = 0;
        m_valid = 0; m_data = '0; m_idx = '0; m_over = 0;
    endtask

    task automatic model_step(input logic fs, input logic [1:0] md, input logic st,
                              input logic bv, input logic [ROW_WIDTH-1:0] bd, input logic rdy);
        bit newwin;
        int k, nbytes;
        logic [63:0] msk;
        if (fs) begin
            m_rows.delete();
            m_n = 0;
`ifdef NN_ROW_WINDOW_ZERO_PAD_EN
            m_rows.push_back('0);
            m_n = 1;
`endif
            m_mode = md; m_stride = st; m_active = 1;
            m_cnt = 0; m_idx = '0; m_over = 0;
        end
        newwin = 0;
        k = int'(m_mode) + 3;
        if (bv && m_active) begin
            nbytes = (k == 3) ? 6 : k;
            msk = (64'h1 << (8 * nbytes)) - 64'h1;
            m_rows.push_back(bd & msk[ROW_WIDTH-1:0]);
            m_n++;
            if (m_rows.size() > MAX_K) void'(m_rows.pop_front());
            if (m_n == k) newwin = 1;
            else if (m_n > k && ((m_n - k) % (int'(m_stride) + 1)) == 0) newwin = 1;
        end
        if (newwin) begin
            if (m_valid && !rdy) m_over = 1;
            m_valid = 1;
            m_data = '0;
            for (int s = 0; s < k; s++)
                m_data[s*ROW_WIDTH +: ROW_WIDTH] = m_rows[m_rows.size() - k + s];
            m_idx = IDX_WIDTH'(m_cnt);
            m_cnt = (m_cnt + 1) % (1 << IDX_WIDTH);
        end else if (rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, WW'(bus.o_win_valid), WW'(m_valid));
        check({tag, ".data"},  bus.o_win_data,        m_data);
        check({tag, ".idx"},   WW'(bus.o_win_idx),   WW'(m_idx));
        check({tag, ".ovf"},   WW'(o_overflow),      WW'(m_over));
        check({tag, ".busy"},  WW'(o_busy),          WW'(m_active));
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge,
    // check at the next falling edge.
    task automatic cyc(input string tag, input logic fs, input logic [1:0] md, input logic st,
                       input logic bv, input logic [ROW_WIDTH-1:0] bd, input logic rdy);
        i_frame_start   = fs;
        i_mode          = md;
        i_stride        = st;
        bus.i_buf_ready = bv;
        bus.i_buf_data  = bd;
        bus.i_win_ready = rdy;
        @(posedge i_clk);
        model_step(fs, md, st, bv, bd, rdy);
        @(negedge i_clk);
        compare_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        i_frame_start = 0; bus.i_buf_ready = 0; bus.i_win_ready = 0;
        i_rst = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge i_clk);
        i_rst = 1'b1;
    endtask

    function automatic logic [ROW_WIDTH-1:0] rnd48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[ROW_WIDTH-1:0];
    endfunction

    logic [ROW_WIDTH-1:0] pat;

    initial begin
        bus.i_buf_data = '0; bus.i_buf_ready = 0; bus.i_win_ready = 0;
        model_reset();
        repeat (2) @(negedge i_clk);
        compare_all("reset");
        i_rst = 1'b1;

        // beats while idle are ignored
        for (int i = 0; i < 3; i++) cyc("idle", 0, 2'b00, 0, 1, rnd48(), 1);

        // mode 00, stride 1, rows 0x11..0x66 pattern
        cyc("a.fs", 1, 2'b00, 0, 0, '0, 1);
        for (int r = 0; r < 5; r++) begin
            pat = 48'h112233445566 + ROW_WIDTH'(r) * 48'h010101010101;
            cyc("a.beat", 0, 2'b00, 0, 1, pat, 1);
        end
        cyc("a.gap", 0, 2'b00, 0, 0, '0, 1);

        // mode 10 byte masking
        cyc("b.fs", 1, 2'b10, 0, 0, '0, 1);
        for (int r = 0; r < 6; r++) cyc("b.beat", 0, 2'b10, 0, 1, 48'hFFFF_FFFF_FFFF, 1);

        // mode 01 stride 2; mid-frame mode/stride changes ignored
        cyc("c.fs", 1, 2'b01, 1, 0, '0, 1);
        for (int r = 0; r < 8; r++) cyc("c.beat", 0, 2'(r), 1'(r), 1, rnd48(), 1);

        // consumer stalled: overflow, then frame start clears it but keeps valid
        cyc("d.fs", 1, 2'b00, 0, 0, '0, 0);
        for (int r = 0; r < 5; r++) cyc("d.beat", 0, 2'b00, 0, 1, rnd48(), 0);
        cyc("d.hold", 0, 2'b00, 0, 0, '0, 0);
        cyc("d.fs2", 1, 2'b11, 0, 0, '0, 0);
        cyc("d.drain", 0, 2'b11, 0, 0, '0, 1);

        // frame start together with a beat, mid-frame
        for (int r = 0; r < 4; r++) cyc("e.beat", 0, 2'b11, 0, 1, rnd48(), 1);
        cyc("e.fsbeat", 1, 2'b00, 1, 1, rnd48(), 1);
        for (int r = 0; r < 5; r++) cyc("e.beat2", 0, 2'b00, 1, 1, rnd48(), 1);

        // reset in SLIDE
        apply_reset("f.rst");
        cyc("f.after", 0, 2'b00, 0, 1, rnd48(), 1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            cyc("rnd", ($urandom_range(0, 39) == 0), 2'($urandom), 1'($urandom),
                ($urandom_range(0, 9) < 6), rnd48(), ($urandom_range(0, 9) < 7));
            if (c == 1500) apply_reset("rnd.rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
